// File: rtl/gcd_host_if.sv
// Host bridge for the GCD CPU: latches operands onto hdin1/hdin2, pulses the CPU reset, then
// returns gcd_answer. Optional macro GCD_HOST_ZERO_BYPASS_EN answers zero-operand pairs directly.
module gcd_host_if #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [31:0] hdin1,
  output logic [31:0] hdin2,
  input  logic [31:0] gcd_answer,
  output logic        cpu_rst_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic              op_ready_q, op_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_timeout_q, res_timeout_d;
  logic              busy_q, busy_d;
  logic [31:0]       hdin1_q, hdin1_d;
  logic [31:0]       hdin2_q, hdin2_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       snapshot_q, snapshot_d;

  logic              accept_s;
  logic              zero_op_s;
  logic              changed_s;
  logic              tmo_hit_s;
  logic              load_done_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  assign accept_s    = op_valid & op_ready_q;
  assign changed_s   = (gcd_answer != snapshot_q);
  assign tmo_hit_s   = (cnt_q == TMO_LAST);
  assign load_done_s = (cnt_q == RST_LAST);
  assign cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

`ifdef GCD_HOST_ZERO_BYPASS_EN
  assign zero_op_s = (op_a == 32'd0) || (op_b == 32'd0);
`else
  assign zero_op_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = zero_op_s ? S_DONE : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_done_s) state_d = S_RUN;
        else             state_d = S_LOAD;
      end
      S_RUN: begin
        if (changed_s || tmo_hit_s) state_d = S_DONE;
        else                        state_d = S_RUN;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    op_ready_d    = op_ready_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    busy_d        = busy_q;
    hdin1_d       = hdin1_q;
    hdin2_d       = hdin2_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    cnt_d         = cnt_q;
    snapshot_d    = snapshot_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          hdin1_d    = op_a;
          hdin2_d    = op_b;
          snapshot_d = gcd_answer;
          cnt_d      = {CNT_W{1'b0}};
          op_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (zero_op_s) begin
            res_data_d    = op_a | op_b;
            res_timeout_d = 1'b0;
            res_valid_d   = 1'b1;
          end else begin
            res_valid_d   = 1'b0;
          end
        end else begin
          op_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_done_s) begin
          cpu_rst_n_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          cnt_d       = cnt_inc_s;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc_s;
        // A change of the answer word outranks a simultaneous timeout
        if (changed_s) begin
          res_data_d    = gcd_answer;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          cpu_rst_n_d   = 1'b0;
        end else if (tmo_hit_s) begin
          res_data_d    = gcd_answer;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          cpu_rst_n_d   = 1'b0;
        end else begin
          res_valid_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          op_ready_d  = 1'b1;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        op_ready_d  = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        cpu_rst_n_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= 32'd0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      hdin1_q       <= 32'd0;
      hdin2_q       <= 32'd0;
      cpu_rst_n_q   <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
      snapshot_q    <= 32'd0;
    end else begin
      op_ready_q    <= op_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      hdin1_q       <= hdin1_d;
      hdin2_q       <= hdin2_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      cnt_q         <= cnt_d;
      snapshot_q    <= snapshot_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign hdin1       = hdin1_q;
  assign hdin2       = hdin2_q;
  assign cpu_rst_n   = cpu_rst_n_q;

endmodule

// File: tb/tb_gcd_host_if.sv
// Bench for gcd_host_if: a job-timeline reference model, a CPU/data-memory stand-in that writes
// gcd(hdin1,hdin2) to word 2 some cycles after release, directed scenarios and random jobs.
module tb_gcd_host_if;

  localparam int RST = 4;
  localparam int TMO = 64;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        busy;
  logic [31:0] hdin1;
  logic [31:0] hdin2;
  logic [31:0] gcd_answer;
  logic        cpu_rst_n;

  gcd_host_if #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout), .busy(busy),
    .hdin1(hdin1), .hdin2(hdin2), .gcd_answer(gcd_answer), .cpu_rst_n(cpu_rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs, plus the job timeline they derive from
  logic        m_op_ready, m_res_valid, m_res_timeout, m_busy, m_cpu_rst_n;
  logic [31:0] m_res_data, m_hdin1, m_hdin2, m_snap;
  bit          m_job;
  int          m_age;
  int          cpu_delay;
  int          cpu_age;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic model_reset();
    m_op_ready = 1'b0; m_res_valid = 1'b0; m_res_timeout = 1'b0; m_busy = 1'b0;
    m_cpu_rst_n = 1'b0; m_res_data = 32'd0; m_hdin1 = 32'd0; m_hdin2 = 32'd0;
    m_snap = 32'd0; m_job = 1'b0; m_age = 0;
  endtask

  task automatic m_finish(input logic [31:0] d, input logic t);
    m_res_valid = 1'b1; m_res_data = d; m_res_timeout = t; m_cpu_rst_n = 1'b0; m_job = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were present at that edge
  task automatic model_edge();
    if (!rst_n) return;
    if (m_res_valid) begin
      if (res_ready) begin
        m_res_valid = 1'b0; m_busy = 1'b0; m_op_ready = 1'b1;
      end
    end else if (m_job) begin
      m_age++;
      if (m_age <= RST) begin
        if (m_age == RST) m_cpu_rst_n = 1'b1;
      end else if (gcd_answer != m_snap) begin
        m_finish(gcd_answer, 1'b0);
      end else if (m_age - RST - 1 == TMO - 1) begin
        m_finish(gcd_answer, 1'b1);
      end
    end else if (m_op_ready && op_valid) begin
      m_hdin1 = op_a; m_hdin2 = op_b; m_snap = gcd_answer;
      m_op_ready = 1'b0; m_busy = 1'b1; m_age = 0;
`ifdef GCD_HOST_ZERO_BYPASS_EN
      if (op_a == 32'd0 || op_b == 32'd0) m_finish(op_a | op_b, 1'b0);
      else m_job = 1'b1;
`else
      m_job = 1'b1;
`endif
    end else begin
      m_op_ready = 1'b1;
    end
  endtask

  // CPU stand-in: once released it writes the GCD of the memory operands after cpu_delay cycles
  task automatic cpu_model();
    if (cpu_rst_n === 1'b1) begin
      if (cpu_age == cpu_delay) gcd_answer = gcd(m_hdin1, m_hdin2);
      cpu_age++;
    end else begin
      cpu_age = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    cpu_model();
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("op_ready", op_ready, m_op_ready);
    chk("res_valid", res_valid, m_res_valid);
    chk("busy", busy, m_busy);
    chk("cpu_rst_n", cpu_rst_n, m_cpu_rst_n);
    chk("hdin1", hdin1, m_hdin1);
    chk("hdin2", hdin2, m_hdin2);
    if (m_res_valid) begin
      chk("res_data", res_data, m_res_data);
      chk("res_timeout", res_timeout, m_res_timeout);
    end
  end

  task automatic wait_op_ready();
    int guard;
    guard = 0;
    while (op_ready !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    chk("wait_op_ready", op_ready, 1'b1);
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input int delay,
                           output int lat, output int rel_at,
                           output logic [31:0] data, output logic tmo);
    int guard;
    wait_op_ready();
    cpu_delay = delay;
    op_a = a; op_b = b; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    lat = 0; rel_at = -1; guard = 0;
    while (res_valid !== 1'b1 && guard < 400) begin
      step();
      lat++;
      guard++;
      if (cpu_rst_n === 1'b1 && rel_at < 0) rel_at = lat;
    end
    chk("wait_res_valid", res_valid, 1'b1);
    data = res_data;
    tmo = res_timeout;
  endtask

  task automatic release_res(input int hold);
    for (int i = 0; i < hold; i++) begin
      op_valid = ($urandom_range(0, 1) == 1);
      op_a = $urandom; op_b = $urandom;
      step();
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int          lat, rel;
    logic [31:0] data, a, b;
    logic        tmo;
    rst_n = 1'b1; op_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; res_ready = 1'b0;
    gcd_answer = 32'd0; cpu_delay = 10; cpu_age = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_res_data", res_data, 32'd0);
    step(); step();
    #3 rst_n = 1'b1;
    step();
    chk("op_ready_after_reset", op_ready, 1'b1);

    // Basic job, answer written ten cycles after release
    start_job(32'd48, 32'd18, 10, lat, rel, data, tmo);
    chk("t1_hdin1", hdin1, 32'd48);
    chk("t1_hdin2", hdin2, 32'd18);
    chk("t1_data", data, 32'd6);
    chk("t1_tmo", {31'd0, tmo}, 32'd0);
    chk("t1_lat", lat, 32'd15);
    chk("t1_cpu_rst_n", cpu_rst_n, 1'b0);
    release_res(2);

    // Same answer as before: completes by timeout, then held result under backpressure
    start_job(32'd12, 32'd18, 10, lat, rel, data, tmo);
    chk("t2_data", data, 32'd6);
    chk("t2_tmo", {31'd0, tmo}, 32'd1);
    chk("t2_lat", lat, RST + TMO);
    for (int i = 0; i < 20; i++) begin
      op_valid = 1'b1; op_a = 32'd99; op_b = 32'd33;
      step();
      chk("t3_res_valid", res_valid, 1'b1);
      chk("t3_res_data", res_data, 32'd6);
      chk("t3_op_ready", op_ready, 1'b0);
      chk("t3_hdin1", hdin1, 32'd12);
    end
    release_res(0);

    // Reset in the middle of RUN
    wait_op_ready();
    cpu_delay = 10;
    op_a = 32'd60; op_b = 32'd45; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    repeat (6) step();
    chk("t4_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t4_op_ready", op_ready, 1'b0);
    chk("t4_res_valid", res_valid, 1'b0);
    chk("t4_res_data", res_data, 32'd0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_hdin1", hdin1, 32'd0);
    chk("t4_cpu_rst_n", cpu_rst_n, 1'b0);
    step(); step();
    #3 rst_n = 1'b1;
    start_job(32'd21, 32'd14, 5, lat, rel, data, tmo);
    chk("t4_data", data, 32'd7);
    chk("t4_tmo", {31'd0, tmo}, 32'd0);
    chk("t4_lat", lat, 32'd10);
    chk("t5_release_edge", rel, RST);
    chk("t5_hdin1", hdin1, 32'd21);
    chk("t5_hdin2", hdin2, 32'd14);
    release_res(1);

    // Zero operand
    start_job(32'd0, 32'd35, 3, lat, rel, data, tmo);
    chk("t6_data", data, 32'd35);
    chk("t6_tmo", {31'd0, tmo}, 32'd0);
`ifdef GCD_HOST_ZERO_BYPASS_EN
    chk("t6_lat", lat, 32'd0);
    chk("t6_no_release", rel, -1);
`else
    chk("t6_lat", lat, 32'd8);
    chk("t6_release_edge", rel, RST);
`endif
    release_res(1);

    // Random jobs, including zero operands and repeated answers
    for (int j = 0; j < 30; j++) begin
      a = $urandom_range(1, 300);
      b = $urandom_range(1, 300);
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      start_job(a, b, $urandom_range(0, 15), lat, rel, data, tmo);
      chk("rand_gcd", data, gcd(a, b));
      release_res($urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
